maxpool_stream_serializer: RTL and testbench

Downstream stage of the 2D max-pool layer. Captures one complete pooled feature map, presented as a wide flat vector with a single-cycle valid strobe, and replays it as a narrow valid/ready beat stream into the fully-connected / flatten stage. The block absorbs the pool stage's lack of back-pressure: one frame buffer, an explicit ready, and an overflow indication when a frame arrives while the previous one is still draining.

---
 rtl/maxpool_stream_serializer.sv | 103 ++++++++++
 tb/tb_maxpool_stream_serializer.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/maxpool_stream_serializer.sv
// Frame buffer between the 2D max-pool stage and the flatten/FC stage: captures one pooled
// map on a single-cycle strobe and replays it as a valid/ready beat stream.
//
//   state  | meaning
//   IDLE   | buffer free, in_ready high, waiting for a frame strobe
//   STREAM | replaying beats; any new frame strobe is dropped and flagged
module maxpool_stream_serializer #(
   parameter int OUTPUT_WIDTH   = 16,
   parameter int OUTPUT_HEIGHT  = 16,
   parameter int INPUT_CHANNELS = 16,
   parameter int ACTIV_BITS     = 8,
   parameter int BEAT_ELEMS     = 4,
   localparam int TOTAL         = OUTPUT_WIDTH * OUTPUT_HEIGHT * INPUT_CHANNELS,
   localparam int NUM_BEATS     = TOTAL / BEAT_ELEMS,
   localparam int BW            = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1,
   localparam int BEAT_BITS     = BEAT_ELEMS * ACTIV_BITS
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [TOTAL*ACTIV_BITS-1:0] in_data,
   input  logic                        in_valid,
   output logic                        in_ready,
   output logic [BEAT_BITS-1:0]        out_data,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [BW-1:0]               out_beat,
   output logic                        out_last,
   output logic                        frame_done,
   output logic                        overflow,
   output logic                        overflow_sticky
);

   localparam logic [0:0]    IDLE      = 1'b0;
   localparam logic [0:0]    STREAM    = 1'b1;
   localparam logic [BW-1:0] LAST_BEAT = BW'(NUM_BEATS - 1);

   logic [0:0]                          state;
   logic [NUM_BEATS-1:0][BEAT_BITS-1:0] frame_buf;
   logic [BW-1:0]                       beat_cnt;
   logic [BW-1:0]                       beat_nxt;
   logic                                xfer;
   logic                                accept;
   logic                                drop;

   assign in_ready  = (state == IDLE) && !rst;
   assign xfer      = out_valid && out_ready;
   assign accept    = in_valid && (state == IDLE);
   assign drop      = in_valid && (state == STREAM);
   assign beat_nxt  = beat_cnt + 1'b1;
   assign out_beat  = beat_cnt;
   assign out_last  = out_valid && (beat_cnt == LAST_BEAT);

   // Buffer holds raw activations only, so it is deliberately left out of reset.
   always_ff @(posedge clk) begin
      if (!rst && accept) begin
         frame_buf <= in_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state           <= IDLE;
         beat_cnt        <= '0;
         out_data        <= '0;
         out_valid       <= 1'b0;
         frame_done      <= 1'b0;
         overflow        <= 1'b0;
         overflow_sticky <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         overflow   <= 1'b0;
         if (drop) begin
            overflow        <= 1'b1;
            overflow_sticky <= 1'b1;
         end
         case (state)
            IDLE: begin
               if (accept) begin
                  beat_cnt  <= '0;
                  out_data  <= in_data[BEAT_BITS-1:0];
                  out_valid <= 1'b1;
                  state     <= STREAM;
               end
            end
            STREAM: begin
               // Without a transfer everything holds, keeping the beat stable under stall.
               if (xfer) begin
                  if (beat_cnt == LAST_BEAT) begin
                     out_valid  <= 1'b0;
                     frame_done <= 1'b1;
                     state      <= IDLE;
                  end else begin
                     beat_cnt <= beat_nxt;
                     out_data <= frame_buf[beat_nxt];
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_maxpool_stream_serializer.sv
// Bench for maxpool_stream_serializer at W=H=C=2, 8-bit activations, 2 per beat (4 beats/frame).
module tb_maxpool_stream_serializer;

   localparam int TOTAL = 8;
   localparam int BE    = 2;
   localparam int NB    = TOTAL / BE;

   logic                 clk;
   logic                 rst;
   logic [TOTAL*8-1:0]   in_data;
   logic                 in_valid;
   logic                 in_ready;
   logic [BE*8-1:0]      out_data;
   logic                 out_valid;
   logic                 out_ready;
   logic [1:0]           out_beat;
   logic                 out_last;
   logic                 frame_done;
   logic                 overflow;
   logic                 overflow_sticky;

   int n_checks = 0;
   int n_err    = 0;

   // Reference state: the beats still owed to the consumer, in order.
   logic [BE*8-1:0] exp_q[$];
   int              exp_idx;
   bit              exp_fd, exp_ovf, exp_sticky, exp_fresh;

   maxpool_stream_serializer #(
      .OUTPUT_WIDTH(2), .OUTPUT_HEIGHT(2), .INPUT_CHANNELS(2),
      .ACTIV_BITS(8), .BEAT_ELEMS(BE)
   ) dut (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_beat(out_beat),
      .out_last(out_last), .frame_done(frame_done), .overflow(overflow),
      .overflow_sticky(overflow_sticky)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [TOTAL*8-1:0] frame_from(input logic [7:0] base);
      logic [TOTAL*8-1:0] f;
      for (int e = 0; e < TOTAL; e++) f[e*8 +: 8] = base + 8'(e);
      return f;
   endfunction

   function automatic logic [TOTAL*8-1:0] frame_rand();
      logic [TOTAL*8-1:0] f;
      for (int e = 0; e < TOTAL; e++) f[e*8 +: 8] = 8'($urandom_range(0, 255));
      return f;
   endfunction

   // Beat b carries elements b*BE+i in lane i.
   function automatic logic [BE*8-1:0] beat_of(input logic [TOTAL*8-1:0] f, input int b);
      logic [BE*8-1:0] r;
      for (int i = 0; i < BE; i++) r[i*8 +: 8] = f[(b*BE + i)*8 +: 8];
      return r;
   endfunction

   task automatic model_step();
      if (rst) begin
         exp_q.delete();
         exp_idx = 0; exp_fd = 0; exp_ovf = 0; exp_sticky = 0; exp_fresh = 1;
      end else begin
         exp_fd = 0; exp_ovf = 0;
         if (exp_q.size() == 0) begin
            if (in_valid) begin
               for (int b = 0; b < NB; b++) exp_q.push_back(beat_of(in_data, b));
               exp_idx = 0; exp_fresh = 0;
            end
         end else begin
            if (in_valid) begin exp_ovf = 1; exp_sticky = 1; end
            if (out_ready) begin
               void'(exp_q.pop_front());
               exp_idx++;
               if (exp_q.size() == 0) exp_fd = 1;
            end
         end
      end
   endtask

   task automatic check_all();
      chk("in_ready", 32'(in_ready), 32'(exp_q.size() == 0 && !rst));
      chk("out_valid", 32'(out_valid), 32'(exp_q.size() > 0));
      if (exp_q.size() > 0) begin
         chk("out_data", 32'(out_data), 32'(exp_q[0]));
         chk("out_beat", 32'(out_beat), 32'(exp_idx));
         chk("out_last", 32'(out_last), 32'(exp_q.size() == 1));
      end else begin
         chk("out_last_idle", 32'(out_last), 32'd0);
      end
      if (exp_fresh) begin
         chk("out_data_rst", 32'(out_data), 32'd0);
         chk("out_beat_rst", 32'(out_beat), 32'd0);
      end
      chk("frame_done", 32'(frame_done), 32'(exp_fd));
      chk("overflow", 32'(overflow), 32'(exp_ovf));
      chk("overflow_sticky", 32'(overflow_sticky), 32'(exp_sticky));
   endtask

   // Advance one clock with the current inputs, then compare at the following negedge.
   task automatic tick();
      model_step();
      @(negedge clk);
      check_all();
   endtask

   initial begin
      logic [3:0] pat;
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
      exp_q.delete(); exp_idx = 0; exp_fd = 0; exp_ovf = 0; exp_sticky = 0; exp_fresh = 1;

      // Reset held for two cycles
      tick();
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      tick();
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      rst = 1'b0;
      tick();
      chk("post_rst_in_ready", 32'(in_ready), 32'd1);

      // Basic frame, out_ready held high
      in_data = frame_from(8'h10); in_valid = 1'b1; out_ready = 1'b1;
      tick(); in_valid = 1'b0;
      chk("basic_b0", 32'(out_data), 32'h1110);
      tick(); chk("basic_b1", 32'(out_data), 32'h1312);
      tick(); chk("basic_b2", 32'(out_data), 32'h1514);
      tick(); chk("basic_b3", 32'(out_data), 32'h1716);
      chk("basic_last", 32'(out_last), 32'd1);
      tick(); chk("basic_done", 32'(frame_done), 32'd1);
      tick();

      // Back-pressure with ready pattern 1,0,0,1,...
      pat = 4'b1001;
      in_data = frame_from(8'h10); in_valid = 1'b1;
      tick(); in_valid = 1'b0;
      for (int k = 0; k < 16; k++) begin
         out_ready = pat[k % 4];
         tick();
      end
      out_ready = 1'b1;
      tick();

      // Overflow while streaming, then at the final-transfer cycle, then back-to-back accept
      in_data = frame_from(8'h10); in_valid = 1'b1;
      tick(); in_valid = 1'b0;                       // T+1
      tick();                                        // T+2
      in_data = frame_from(8'hA0); in_valid = 1'b1;
      tick(); in_valid = 1'b0;                       // T+3
      chk("ovf_pulse", 32'(overflow), 32'd1);
      chk("ovf_sticky", 32'(overflow_sticky), 32'd1);
      chk("ovf_b2_intact", 32'(out_data), 32'h1514);
      tick();                                        // T+4
      chk("ovf_last", 32'(out_last), 32'd1);
      in_valid = 1'b1;
      tick(); in_valid = 1'b0;                       // T+5
      chk("ovf_final_drop", 32'(overflow), 32'd1);
      chk("ovf_done", 32'(frame_done), 32'd1);
      in_data = frame_from(8'h30); in_valid = 1'b1;
      tick(); in_valid = 1'b0;                       // T+6
      chk("b2b_b0", 32'(out_data), 32'h3130);
      chk("b2b_sticky", 32'(overflow_sticky), 32'd1);
      for (int k = 0; k < 5; k++) tick();

      // Mid-frame reset after beat 1 transfers
      in_data = frame_from(8'h50); in_valid = 1'b1;
      tick(); in_valid = 1'b0;                       // T+1 beat0
      tick();                                        // T+2 beat1
      tick();                                        // T+3
      rst = 1'b1;
      tick();
      chk("midrst_valid", 32'(out_valid), 32'd0);
      rst = 1'b0;
      for (int k = 0; k < 3; k++) tick();
      in_data = frame_from(8'h60); in_valid = 1'b1;
      tick(); in_valid = 1'b0;
      chk("midrst_restart_beat", 32'(out_beat), 32'd0);
      for (int k = 0; k < 5; k++) tick();

      // Randomized traffic against the queue model
      for (int k = 0; k < 600; k++) begin
         rst       = ($urandom_range(0, 149) == 0);
         in_valid  = ($urandom_range(0, 3) == 0);
         in_data   = frame_rand();
         out_ready = ($urandom_range(0, 2) != 0);
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
